// File: rtl/uart_text_console_if.sv
// Signal bundle shared by the UART receiver, the text console writer and the character BRAM / VGA reader.
interface uart_text_console_if #(
    parameter int COLS       = 80,
    parameter int ROWS       = 60,
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 7
);
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    // uart_flag is a one-cycle strobe with no backpressure: a byte is taken when
    // ready is high, parked in a one-entry holding register otherwise, and dropped
    // (overrun pulses one cycle later) when that register is already occupied.
    logic                  uart_flag;
    logic [DATA_WIDTH-1:0] uart_data;
    logic                  ready;
    logic                  overrun;
    logic                  bram_wen;
    logic [ADDR_WIDTH-1:0] bram_addr;
    logic [DATA_WIDTH-1:0] bram_data;
    logic [COL_W-1:0]      cursor_col;
    logic [ROW_W-1:0]      cursor_row;
    logic [ROW_W-1:0]      scroll_row;
    logic [1:0]            fsm_state;

    modport master (
        output uart_flag, uart_data,
        input  ready, overrun, bram_wen, bram_addr, bram_data,
        input  cursor_col, cursor_row, scroll_row, fsm_state
    );

    modport slave (
        input  uart_flag, uart_data,
        output ready, overrun, bram_wen, bram_addr, bram_data,
        output cursor_col, cursor_row, scroll_row, fsm_state
    );
endinterface

// File: rtl/uart_text_console.sv
// Terminal-style writer from UART bytes into a character BRAM with pointer-rotation scrolling.
// Define UART_TEXT_CONSOLE_BACKSPACE_EN to make 0x08 erase the cell left of the cursor.
module uart_text_console #(
    parameter int                    COLS       = 80,
    parameter int                    ROWS       = 60,
    parameter int                    ADDR_WIDTH = 13,
    parameter int                    DATA_WIDTH = 7,
    parameter logic [DATA_WIDTH-1:0] BLANK      = '0
) (
    input  logic               clk,
    input  logic               resetn,
    uart_text_console_if.slave bus
);
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CNT_W = ADDR_WIDTH + 1;

    localparam logic [CNT_W-1:0]      CELLS_C    = CNT_W'(COLS * ROWS);
    localparam logic [CNT_W-1:0]      CLR_LAST   = CNT_W'(COLS - 1);
    localparam logic [COL_W-1:0]      LAST_COL   = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]      LAST_ROW   = ROW_W'(ROWS - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_BASE  = ADDR_WIDTH'((ROWS - 1) * COLS);
    localparam logic [ADDR_WIDTH-1:0] ROW_STEP   = ADDR_WIDTH'(COLS);
    localparam logic [DATA_WIDTH-1:0] CH_CR      = DATA_WIDTH'(8'h0D);
    localparam logic [DATA_WIDTH-1:0] CH_LF      = DATA_WIDTH'(8'h0A);
    localparam logic [DATA_WIDTH-1:0] CH_SPACE   = DATA_WIDTH'(8'h20);
    localparam logic [DATA_WIDTH-1:0] CH_DEL     = DATA_WIDTH'(8'h7F);
`ifdef UART_TEXT_CONSOLE_BACKSPACE_EN
    localparam logic [DATA_WIDTH-1:0] CH_BS      = DATA_WIDTH'(8'h08);
`endif

    typedef enum logic [1:0] {INIT = 2'd0, IDLE = 2'd1, CLEAR = 2'd2} state_t;

    state_t                state, state_nxt;
    logic                  hold_valid, hold_valid_nxt;
    logic [DATA_WIDTH-1:0] hold_data;
    logic [COL_W-1:0]      col, col_nxt;
    logic [ROW_W-1:0]      row, scroll, next_row, next_scroll;
    logic [ADDR_WIDTH-1:0] base, next_base, cur_addr, wr_addr;
    logic [CNT_W-1:0]      cnt;
    logic [DATA_WIDTH-1:0] ch, wr_data;
    logic                  take, is_print, wr, nl, scroll_now, store, drop;
    logic                  wen_q, ready_q, overrun_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;

    always_comb begin
        take        = (state == IDLE) && (hold_valid || bus.uart_flag);
        ch          = hold_valid ? hold_data : bus.uart_data;
        next_row    = (row == LAST_ROW) ? '0 : row + ROW_W'(1);
        next_scroll = (scroll == LAST_ROW) ? '0 : scroll + ROW_W'(1);
        next_base   = (base == LAST_BASE) ? '0 : base + ROW_STEP;
        cur_addr    = base + ADDR_WIDTH'(col);
        // Codes >= 0x80 are printable too, so one unsigned compare covers both ranges.
        is_print    = (ch >= CH_SPACE) && (ch != CH_DEL);

        col_nxt = col;
        nl      = 1'b0;
        wr      = 1'b0;
        wr_addr = cur_addr;
        wr_data = ch;
        if (take) begin
            if (ch == CH_CR) begin
                col_nxt = '0;
            end else if (ch == CH_LF) begin
                nl = 1'b1;
`ifdef UART_TEXT_CONSOLE_BACKSPACE_EN
            end else if (ch == CH_BS) begin
                if (col != '0) begin
                    col_nxt = col - COL_W'(1);
                    wr      = 1'b1;
                    wr_addr = cur_addr - ADDR_WIDTH'(1);
                    wr_data = BLANK;
                end
`endif
            end else if (is_print) begin
                wr = 1'b1;
                if (col == LAST_COL) begin
                    col_nxt = '0;
                    nl      = 1'b1;
                end else begin
                    col_nxt = col + COL_W'(1);
                end
            end
        end
        // The cursor leaves the last visible row exactly when its next row is the top row.
        scroll_now = nl && (next_row == scroll);

        case (state)
            INIT:    state_nxt = (cnt == CELLS_C) ? IDLE : INIT;
            CLEAR:   state_nxt = (cnt == CLR_LAST) ? IDLE : CLEAR;
            IDLE:    state_nxt = scroll_now ? CLEAR : IDLE;
            default: state_nxt = INIT;
        endcase

        drop           = bus.uart_flag && hold_valid && (state != IDLE);
        store          = bus.uart_flag && !drop && !((state == IDLE) && !hold_valid);
        hold_valid_nxt = store ? 1'b1 : ((state == IDLE) ? 1'b0 : hold_valid);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= INIT;
            hold_valid <= 1'b0;
            hold_data  <= '0;
            col        <= '0;
            row        <= '0;
            scroll     <= '0;
            base       <= '0;
            cnt        <= '0;
            wen_q      <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            ready_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state      <= state_nxt;
            hold_valid <= hold_valid_nxt;
            if (store) hold_data <= bus.uart_data;
            overrun_q  <= drop;
            ready_q    <= (state_nxt == IDLE) && !hold_valid_nxt;
            wen_q      <= 1'b0;

            case (state)
                INIT: begin
                    if (cnt != CELLS_C) begin
                        wen_q  <= 1'b1;
                        addr_q <= cnt[ADDR_WIDTH-1:0];
                        data_q <= BLANK;
                        cnt    <= cnt + CNT_W'(1);
                    end
                end
                CLEAR: begin
                    wen_q  <= 1'b1;
                    addr_q <= base + cnt[ADDR_WIDTH-1:0];
                    data_q <= BLANK;
                    cnt    <= cnt + CNT_W'(1);
                end
                IDLE: begin
                    col <= col_nxt;
                    if (wr) begin
                        wen_q  <= 1'b1;
                        addr_q <= wr_addr;
                        data_q <= wr_data;
                    end
                    if (nl) begin
                        row  <= next_row;
                        base <= next_base;
                    end
                    if (scroll_now) begin
                        scroll <= next_scroll;
                        cnt    <= '0;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

    assign bus.bram_wen   = wen_q;
    assign bus.bram_addr  = addr_q;
    assign bus.bram_data  = data_q;
    assign bus.ready      = ready_q;
    assign bus.overrun    = overrun_q;
    assign bus.cursor_col = col;
    assign bus.cursor_row = row;
    assign bus.scroll_row = scroll;
    assign bus.fsm_state  = state;
endmodule

// File: tb/tb_uart_text_console.sv
// Directed bench for uart_text_console on a 4x3 screen: init clear, decode, wrap, scroll, overrun, reset abort.
module tb_uart_text_console;
  localparam int COLS = 4;
  localparam int ROWS = 3;
  localparam int AW   = 4;
  localparam int DW   = 7;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  logic [AW-1:0] exp_q[$];

  uart_text_console_if #(.COLS(COLS), .ROWS(ROWS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  uart_text_console #(
    .COLS(COLS), .ROWS(ROWS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BLANK('0)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the next negedge with the strobe's result visible.
  task automatic strobe(input logic [DW-1:0] c);
    bus.uart_flag = 1'b1;
    bus.uart_data = c;
    @(negedge clk);
    bus.uart_flag = 1'b0;
  endtask

  task automatic expect_wr(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d);
    check({tag, "_wen"}, 32'(bus.bram_wen), 32'd1);
    check({tag, "_addr"}, 32'(bus.bram_addr), 32'(a));
    check({tag, "_data"}, 32'(bus.bram_data), 32'(d));
  endtask

  task automatic expect_nowr(input string tag);
    check({tag, "_wen"}, 32'(bus.bram_wen), 32'd0);
  endtask

  task automatic expect_cursor(input string tag, input int c, input int r, input int s);
    check({tag, "_col"}, 32'(bus.cursor_col), 32'(c));
    check({tag, "_row"}, 32'(bus.cursor_row), 32'(r));
    check({tag, "_scroll"}, 32'(bus.scroll_row), 32'(s));
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    bus.uart_flag = 1'b0;
    #1;
    check("rst_wen", 32'(bus.bram_wen), 32'd0);
    check("rst_addr", 32'(bus.bram_addr), 32'd0);
    check("rst_data", 32'(bus.bram_data), 32'd0);
    check("rst_ready", 32'(bus.ready), 32'd0);
    check("rst_overrun", 32'(bus.overrun), 32'd0);
    expect_cursor("rst", 0, 0, 0);
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < COLS * ROWS; i++) exp_q.push_back(AW'(i));
    while (exp_q.size() > 0) begin
      @(negedge clk);
      expect_wr("init", exp_q.pop_front(), '0);
      check("init_ready", 32'(bus.ready), 32'd0);
    end
    @(negedge clk);
    check("init_done_ready", 32'(bus.ready), 32'd1);
    expect_nowr("init_done");
    expect_cursor("init_done", 0, 0, 0);
  endtask

  initial begin
    bus.uart_flag = 1'b0;
    bus.uart_data = '0;
    do_reset();

    // "AB", CR, "C"
    strobe(7'h41); expect_wr("A", 0, 7'h41); check("A_col", 32'(bus.cursor_col), 32'd1);
    strobe(7'h42); expect_wr("B", 1, 7'h42); check("B_col", 32'(bus.cursor_col), 32'd2);
    strobe(7'h0D); expect_nowr("CR"); check("CR_col", 32'(bus.cursor_col), 32'd0);
    strobe(7'h43); expect_wr("C", 0, 7'h43); check("C_col", 32'(bus.cursor_col), 32'd1);

    // ignored control code, then LF keeps the column
    strobe(7'h01); expect_nowr("ctl"); expect_cursor("ctl", 1, 0, 0);
    strobe(7'h7F); expect_nowr("del"); expect_cursor("del", 1, 0, 0);
    strobe(7'h0A); expect_nowr("LF"); expect_cursor("LF", 1, 1, 0);

    // "XY", backspace on row 1 (base 4)
    strobe(7'h0D); expect_nowr("CR2");
    strobe(7'h58); expect_wr("X", 4, 7'h58);
    strobe(7'h59); expect_wr("Y", 5, 7'h59); check("Y_col", 32'(bus.cursor_col), 32'd2);
    strobe(7'h08);
`ifdef UART_TEXT_CONSOLE_BACKSPACE_EN
    expect_wr("bs", 5, '0); check("bs_col", 32'(bus.cursor_col), 32'd1);
`else
    expect_nowr("bs"); check("bs_col", 32'(bus.cursor_col), 32'd2);
`endif
    strobe(7'h0D);
    strobe(7'h08); expect_nowr("bs_col0"); expect_cursor("bs_col0", 0, 1, 0);

    // 12 printables from a fresh screen: wraps after 4th and 8th, scroll after 12th
    do_reset();
    for (int i = 0; i < 12; i++) begin
      strobe(DW'(32'h61 + i));
      expect_wr("fill", AW'(i), DW'(32'h61 + i));
      expect_cursor("fill", (i + 1) % 4, ((i + 1) / 4) % 3, (i == 11) ? 1 : 0);
      check("fill_ready", 32'(bus.ready), (i == 11) ? 32'd0 : 32'd1);
    end

    // three back-to-back strobes while the new row 0 is cleared
    bus.uart_flag = 1'b1;
    bus.uart_data = 7'h48;
    @(negedge clk);
    expect_wr("clr0", 0, '0); check("clr0_ovr", 32'(bus.overrun), 32'd0);
    check("clr0_ready", 32'(bus.ready), 32'd0);
    bus.uart_data = 7'h49;
    @(negedge clk);
    expect_wr("clr1", 1, '0); check("clr1_ovr", 32'(bus.overrun), 32'd1);
    check("clr1_ready", 32'(bus.ready), 32'd0);
    bus.uart_data = 7'h4A;
    @(negedge clk);
    expect_wr("clr2", 2, '0); check("clr2_ovr", 32'(bus.overrun), 32'd1);
    check("clr2_ready", 32'(bus.ready), 32'd0);
    bus.uart_flag = 1'b0;
    @(negedge clk);
    expect_wr("clr3", 3, '0); check("clr3_ovr", 32'(bus.overrun), 32'd0);
    check("clr3_ready", 32'(bus.ready), 32'd0);
    @(negedge clk);
    expect_wr("held", 0, 7'h48); expect_cursor("held", 1, 0, 1);
    check("held_ready", 32'(bus.ready), 32'd1);
    check("held_ovr", 32'(bus.overrun), 32'd0);

    // LF from the last visible row scrolls again; reset lands mid-clear
    strobe(7'h0A); expect_nowr("LF_scroll"); expect_cursor("LF_scroll", 1, 1, 2);
    check("LF_scroll_ready", 32'(bus.ready), 32'd0);
    @(negedge clk);
    expect_wr("clrb0", 4, '0);
    do_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_text_console.md
# uart_text_console

Parametrised UART-to-character-buffer writer with terminal semantics. It sits between the UART receiver and the VGA character BRAM. It keeps a cursor, handles CR, LF and optional backspace, and auto-wraps at the end of a line. When the cursor passes the last visible row it scrolls the screen by rotating a top-row pointer that the VGA reader consumes; it never copies buffer contents. The screen is cleared after reset, and each newly exposed line is cleared.

## Interface
- COLS, 80, characters per row
- ROWS, 60, rows per screen
- ADDR_WIDTH, 13, BRAM address width; must satisfy 2^ADDR_WIDTH >= COLS*ROWS
- DATA_WIDTH, 7, character code width; must be >= 7
- BLANK, 0, code written when clearing or erasing a cell

Ports:
- clk  in  1  system clock
- resetn  in  1  reset, asynchronous, active-low
- uart_flag  in  1  one-cycle strobe, uart_data valid
- uart_data  in  DATA_WIDTH  received character
- ready  out  1  high when a strobe will be processed without buffering
- overrun  out  1  one-cycle pulse when a byte is dropped
- bram_wen  out  1  BRAM write enable
- bram_addr  out  ADDR_WIDTH  write address, row*COLS+col (physical row)
- bram_data  out  DATA_WIDTH  write data
- cursor_col  out  $clog2(COLS)  cursor column
- cursor_row  out  $clog2(ROWS)  cursor physical row
- scroll_row  out  $clog2(ROWS)  physical row shown at top of screen

## Operation
- States: INIT, IDLE, CLEAR.
- INIT writes BLANK to addresses 0..COLS*ROWS-1, one per cycle, then enters IDLE.
- CLEAR writes BLANK to the COLS cells of the cursor row, then enters IDLE.
- In IDLE a byte is taken from the holding register first; otherwise it is taken from a uart_flag in that cycle.
- Holding register: 1 entry. A strobe arriving in INIT or CLEAR, or in IDLE while the held byte is being drained, is stored.
  - If the holding register is already full, the byte is dropped and overrun pulses.
- Decode:
  - 0x0D (CR): col=0; no write.
  - 0x0A (LF): newline; col is unchanged; no write.
  - 0x20..0x7E and codes >= 0x80: write at cursor, then col+1. At col=COLS-1, write, then col=0 and newline.
  - Other codes in 0x00..0x1F, and 0x7F: ignored; no write, no move.
- Newline: let vrow = (cursor_row - scroll_row) mod ROWS.
  - If vrow < ROWS-1: row = (row+1) mod ROWS, then IDLE.
  - If vrow = ROWS-1: row = (row+1) mod ROWS and scroll_row = (scroll_row+1) mod ROWS, then CLEAR on the new row.
- Row base address is kept as a register: +COLS per row, wrapping from (ROWS-1)*COLS to 0. No multiplier.
- ready = (state==IDLE) and holding register empty.

## Timing
- Reset values: bram_wen=0, bram_addr=0, bram_data=0, cursor_col=0, cursor_row=0, scroll_row=0, ready=0, overrun=0; state=INIT; holding register empty.
- Asserting resetn low mid-operation aborts at once. INIT restarts on the first clk edge after deassertion.
- INIT takes COLS*ROWS cycles; ready rises in the following cycle.
- A byte accepted in cycle N produces bram_wen=1 in cycle N+1, with the cursor address from cycle N. Cursor outputs update on the same edge.
- All outputs are registered.
- CLEAR: COLS consecutive cycles of bram_wen=1, bram_addr=base+0..COLS-1, bram_data=BLANK. scroll_row has already changed in the first CLEAR cycle.
- A wrap or scroll caused by a printable character follows its write directly: write in N+1, CLEAR from N+2.
- A held byte is processed in the first IDLE cycle. A strobe in that same cycle goes to the holding register.
- overrun is asserted in the cycle after the dropped strobe.

## Configuration
- UART_TEXT_CONSOLE_BACKSPACE_EN defined: 0x08 with col>0 sets col-1 and writes BLANK there (1 cycle). With col=0 it has no effect and does not cross lines.
- Undefined: 0x08 is treated as an ignored control code.

## Test plan
- Reset release with COLS=4, ROWS=3 -> 12 writes of BLANK at addresses 0..11, then ready=1; cursor (0,0); scroll_row=0.
- "AB", CR, "C" at COLS=80 -> writes 'A'@0, 'B'@1, 'C'@0; cursor_col=1.
- COLS=4, ROWS=3: 12 printables -> the 4th, 8th and 12th wrap the cursor.
  - 12th write is at address 11, then scroll_row=1, cursor_row=0, and CLEAR writes addresses 0..3.
  - ready is low for those 4 cycles.
- Three strobes back-to-back during CLEAR -> first is held, second and third are dropped. overrun pulses twice; the held byte is written at 0 when CLEAR ends.
- With the BACKSPACE macro: "XY", 0x08 -> BLANK@1, cursor_col=1. 0x08 at col 0 -> no write. Without the macro -> 0x08 gives no write and no move.
- resetn low during CLEAR -> outputs reset immediately; INIT restarts and completes the full 12-cell clear.
